// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one request at a time, fixed LATENCY, response held until taken.
// Optional alignment fault checking is enabled by defining DMEM_RESPONDER_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          wr_q;
  logic [AW-1:0] word_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, enter_resp, op_write, misalign;
  logic [AW-1:0] op_word;
  logic [31:0]   op_wdata;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;
  // With LATENCY==1 the memory op happens on the accept edge itself, so it uses the live inputs.
  assign enter_resp = (accept && LATENCY == 1) || (state == BUSY && cnt == 4'd1);
  assign op_write   = req_ready ? req_write           : wr_q;
  assign op_word    = req_ready ? req_addr[AW+1:2]    : word_q;
  assign op_wdata   = req_ready ? req_wdata           : wdata_q;

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  logic [1:0] lsb_q;
  assign misalign = req_ready ? (req_addr[1:0] != 2'b00) : (lsb_q != 2'b00);
  always_ff @(posedge clk) begin
    if (reset)       lsb_q <= 2'b00;
    else if (accept) lsb_q <= req_addr[1:0];
  end
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];
`else
  assign misalign = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        word_q  <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        if (op_write && !misalign) mem[op_word] <= op_wdata;
        rdata_q <= (op_write || misalign) ? 32'd0 : mem[op_word];
        err_q   <= misalign;
      end
      case (state)
        IDLE: if (accept) begin
          if (LATENCY == 1) state <= RESP;
          else begin
            state <= BUSY;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt == 4'd1) state <= RESP;
          cnt <= cnt - 4'd1;
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_err   = resp_valid ? err_q   : 1'b0;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a word-array model.
// Build with DMEM_RESPONDER_ALIGN_CHECK_EN defined to exercise the alignment-fault variant.
module tb_dmem_responder;
  localparam int LAT   = 4;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mdl [DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
  endtask

  // Transaction-level view: a store updates the word, a load returns it; faults leave memory alone.
  task automatic model_op(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
    int unsigned idx;
    idx = (a >> 2) % DEPTH;
    er = 1'b0;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    er = (a % 4) != 0;
`endif
    rd = 32'd0;
    if (!er) begin
      if (w) mdl[idx] = wd;
      else   rd = mdl[idx];
    end
  endtask

  // Drives one request, measures accept-to-valid latency (99 on timeout), holds the response
  // for 'hold' cycles and reports whether it stayed stable. 'junk' keeps req_valid high with
  // random contents while the request is in flight.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input int hold, input logic junk,
                      output int lat, output logic [31:0] rd, output logic er,
                      output logic stable, output logic rdy_busy);
    int waitc;
    lat = 99; rd = 32'hx; er = 1'bx; stable = 1'b1; rdy_busy = 1'b0;
    @(negedge clk);
    waitc = 0;
    while (req_ready !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
    if (req_ready !== 1'b1) return;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    if (junk) begin
      req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    end else req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (req_ready === 1'b1) rdy_busy = 1'b1;
      if (resp_valid === 1'b1) begin lat = c; break; end
    end
    if (lat == 99) begin req_valid = 1'b0; return; end
    rd = resp_rdata; er = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er) stable = 1'b0;
      if (req_ready !== 1'b0) rdy_busy = 1'b1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_tests++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd, erd; logic er, eer, st, rb;
    model_op(1'b1, 32'h10, 32'hDEADBEEF, erd, eer);
    xact(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, lat, rd, er, st, rb);
    n_tests++; if (lat != LAT) begin n_fail++; $display("FAIL store_latency got %0d want %0d", lat, LAT); end
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL store_rdata got %h want 0", rd); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_err got %b want 0", er); end
    model_op(1'b0, 32'h10, 32'd0, erd, eer);
    xact(1'b0, 32'h10, 32'd0, 0, 1'b0, lat, rd, er, st, rb);
    n_tests++; if (lat != LAT) begin n_fail++; $display("FAIL load_latency got %0d want %0d", lat, LAT); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata got %h want deadbeef", rd); end
  endtask

  task automatic test_stall();
    int lat; logic [31:0] rd, erd; logic er, eer, st, rb;
    model_op(1'b0, 32'h10, 32'd0, erd, eer);
    xact(1'b0, 32'h10, 32'd0, 3, 1'b0, lat, rd, er, st, rb);
    n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL stall_stable got %b want 1", st); end
    n_tests++; if (rb !== 1'b0) begin n_fail++; $display("FAIL stall_req_ready_low got %b want 0", rb); end
    n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL stall_rdata got %h want %h", rd, erd); end
    @(negedge clk);
    n_tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      begin n_fail++; $display("FAIL stall_back_to_idle got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd, erd; logic er, eer, st, rb;
    model_op(1'b1, 32'h1000, 32'h12345678, erd, eer);
    xact(1'b1, 32'h1000, 32'h12345678, 0, 1'b0, lat, rd, er, st, rb);
    model_op(1'b0, 32'h0, 32'd0, erd, eer);
    xact(1'b0, 32'h0, 32'd0, 0, 1'b0, lat, rd, er, st, rb);
    n_tests++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL wrap_rdata got %h want 12345678", rd); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er, st, rb, seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready_after_reset got %b want 1", req_ready); end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (resp_valid !== 1'b0) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_response got %b want 0", seen); end
    xact(1'b0, 32'h20, 32'd0, 0, 1'b0, lat, rd, er, st, rb);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL abort_no_store got %h want 0", rd); end
    xact(1'b0, 32'h10, 32'd0, 0, 1'b0, lat, rd, er, st, rb);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL abort_mem_cleared got %h want 0", rd); end
  endtask

  task automatic test_align();
    int lat; logic [31:0] rd, erd; logic er, eer, st, rb;
    model_op(1'b1, 32'h22, 32'h55AA55AA, erd, eer);
    xact(1'b1, 32'h22, 32'h55AA55AA, 0, 1'b0, lat, rd, er, st, rb);
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL align_err got %b want 1", er); end
`else
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL align_err got %b want 0", er); end
`endif
    n_tests++; if (lat != LAT) begin n_fail++; $display("FAIL align_latency got %0d want %0d", lat, LAT); end
    model_op(1'b0, 32'h20, 32'd0, erd, eer);
    xact(1'b0, 32'h20, 32'd0, 0, 1'b0, lat, rd, er, st, rb);
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL align_suppressed got %h want 0", rd); end
`else
    n_tests++; if (rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL align_stored got %h want 55aa55aa", rd); end
`endif
  endtask

  task automatic test_random();
    int lat, hold; logic [31:0] a, wd, rd, erd; logic w, er, eer, st, rb;
    for (int n = 0; n < 60; n++) begin
      w    = 1'($urandom_range(0, 1));
      a    = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 12);
      if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
      wd   = $urandom;
      hold = $urandom_range(0, 2);
      model_op(w, a, wd, erd, eer);
      xact(w, a, wd, hold, 1'b1, lat, rd, er, st, rb);
      n_tests++; if (lat != LAT) begin n_fail++; $display("FAIL rand_latency #%0d got %0d want %0d", n, lat, LAT); end
      n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL rand_rdata #%0d addr %h got %h want %h", n, a, rd, erd); end
      n_tests++; if (er !== eer) begin n_fail++; $display("FAIL rand_err #%0d addr %h got %b want %b", n, a, er, eer); end
      n_tests++; if (st !== 1'b1 || rb !== 1'b0)
        begin n_fail++; $display("FAIL rand_hold #%0d got stable=%b ready_seen=%b want 1/0", n, st, rb); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_stall();
    test_wrap();
    test_reset_abort();
    test_align();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
